// File: rtl/fadd_norm_pack_pkg.sv
// Shared FPU definitions for the adder pack stage: FSM encoding and binary32 constants.
package fadd_norm_pack_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_INF  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

endpackage

// File: rtl/fadd_norm_pack_if.sv
// Operand-in / result-out handshake bundle between the mantissa adder, the pack stage and writeback.
interface fadd_norm_pack_if;

    logic        in_valid;
    logic        in_ready;
    logic [24:0] mant_sum;
    logic [2:0]  grs_in;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_nx;

    modport master (
        output in_valid, mant_sum, grs_in, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_nx
    );

    modport slave (
        input  in_valid, mant_sum, grs_in, exp_in, sign_in, out_ready,
        output in_ready, out_valid, result, flag_ovf, flag_unf, flag_nx
    );

endinterface

// File: rtl/fadd_norm_pack_round.sv
// Round-to-nearest-even on a 24-bit significand; shared with the multiplier pack stage.
module fp_round_rne (
    input  logic [23:0] i_mant,
    input  logic        i_g,
    input  logic        i_r,
    input  logic        i_s,
    output logic [23:0] o_mant,
    output logic        o_carry
);

    logic w_up;

    // A tie (g set, r/s clear) rounds up only when the kept LSB is odd.
    assign w_up              = i_g & (i_r | i_s | i_mant[0]);
    assign {o_carry, o_mant} = {1'b0, i_mant} + {24'd0, w_up};

endmodule

// File: rtl/fadd_norm_pack.sv
// FP adder final stage: normalizes the raw sum one bit per cycle, rounds RNE and packs binary32 with flags.
module fadd_norm_pack
    import fadd_norm_pack_pkg::*;
#(
    parameter int NORM_MAX = 24,
    parameter int EXP_BIAS = fadd_norm_pack_pkg::EXP_BIAS
) (
    input  logic             clk,
    input  logic             rst_n,
    fadd_norm_pack_if.slave  bus
);

    localparam logic signed [9:0] EXP_OVF    = 10'(2 * EXP_BIAS + 1);
    localparam logic signed [9:0] EXP_MIN    = 10'sd1;
    localparam logic [4:0]        NSHIFT_MAX = 5'(NORM_MAX);

    state_t             r_state;
    state_t             w_next;
    logic [24:0]        r_mant;
    logic               r_g, r_r, r_s;
    logic signed [9:0]  r_exp;
    logic               r_sign;
    logic [4:0]         r_nshift;
    logic [31:0]        r_result;
    logic               r_ovf, r_unf, r_nx;

    logic               w_is_zero;
    logic [24:0]        w_norm_mant;
    logic signed [9:0]  w_norm_exp;
    logic [4:0]         w_norm_cnt;
    logic               w_norm_exit;
    logic [23:0]        w_rnd_mant;
    logic               w_rnd_carry;
    logic [23:0]        w_fin_mant;
    logic signed [9:0]  w_fin_exp;
    logic               w_inexact;
    logic [31:0]        w_pack_result;
    logic               w_pack_ovf, w_pack_unf, w_pack_nx;

    assign w_is_zero   = (r_mant == 25'd0) && !(r_g | r_r | r_s);
    assign w_norm_mant = {r_mant[23:0], r_g};
    assign w_norm_exp  = r_exp - 10'sd1;
    assign w_norm_cnt  = r_nshift + 5'd1;
    // Exit tests look at the post-shift values so the last shift and the exit share a cycle.
    assign w_norm_exit = w_norm_mant[23] || (w_norm_exp <= EXP_MIN) || (w_norm_cnt == NSHIFT_MAX);

    fp_round_rne u_round (
        .i_mant  (r_mant[23:0]),
        .i_g     (r_g),
        .i_r     (r_r),
        .i_s     (r_s),
        .o_mant  (w_rnd_mant),
        .o_carry (w_rnd_carry)
    );

    assign w_fin_mant = w_rnd_carry ? {1'b1, w_rnd_mant[23:1]} : w_rnd_mant;
    assign w_fin_exp  = r_exp + $signed({9'd0, w_rnd_carry});
    assign w_inexact  = r_g | r_r | r_s;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_pack_result = {r_sign, w_fin_exp[7:0], w_fin_mant[22:0]};
        w_pack_ovf    = 1'b0;
        w_pack_unf    = 1'b0;
        w_pack_nx     = w_inexact;
        if (w_fin_exp >= EXP_OVF) begin
            w_pack_result = POS_INF | {r_sign, 31'd0};
            w_pack_ovf    = 1'b1;
            w_pack_nx     = 1'b1;
        end else if (!w_fin_mant[23]) begin
            w_pack_result = {r_sign, 8'd0, w_fin_mant[22:0]};
            w_pack_unf    = w_inexact;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_ALIGN;
            S_ALIGN: begin
                if (w_is_zero)                    w_next = S_DONE;
                else if (r_mant[24] || r_mant[23]) w_next = S_ROUND;
                else                               w_next = S_NORM;
            end
            S_NORM:  if (w_norm_exit) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mant   <= '0;
            r_g      <= 1'b0;
            r_r      <= 1'b0;
            r_s      <= 1'b0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_nshift <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_nx     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_mant   <= bus.mant_sum;
                    {r_g, r_r, r_s} <= bus.grs_in;
                    r_exp    <= $signed({2'b00, bus.exp_in});
                    r_sign   <= bus.sign_in;
                    r_nshift <= '0;
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                    r_unf    <= 1'b0;
                    r_nx     <= 1'b0;
                end
                S_ALIGN: if (r_mant[24]) begin
                    r_mant <= {1'b0, r_mant[24:1]};
                    r_g    <= r_mant[0];
                    r_r    <= r_g;
                    r_s    <= r_r | r_s;
                    r_exp  <= r_exp + 10'sd1;
                end
                S_NORM: begin
                    r_mant   <= w_norm_mant;
                    r_g      <= r_r;
                    r_r      <= 1'b0;
                    r_exp    <= w_norm_exp;
                    r_nshift <= w_norm_cnt;
                end
                S_ROUND: begin
                    r_result <= w_pack_result;
                    r_ovf    <= w_pack_ovf;
                    r_unf    <= w_pack_unf;
                    r_nx     <= w_pack_nx;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.flag_ovf  = r_ovf;
    assign bus.flag_unf  = r_unf;
    assign bus.flag_nx   = r_nx;

endmodule

// File: tb/tb_fadd_norm_pack.sv
// Self-checking bench for fadd_norm_pack: directed vectors, handshake corners and a random sweep against a value-level model.
module tb_fadd_norm_pack;

    typedef struct {
        logic [24:0] mant;
        logic [2:0]  grs;
        logic [7:0]  exp;
        logic        sign;
        logic [31:0] res;
        logic [2:0]  flags;   // {ovf, unf, nx}
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    fadd_norm_pack_if bus ();

    fadd_norm_pack #(.NORM_MAX(24), .EXP_BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Value-level reference: treat {mant_sum, grs} as an integer scaled by 2^(exp-153),
    // normalize within the exponent/shift limits, then round half-to-even on the dropped bits.
    function automatic void model(input logic [24:0] m_in, input logic [2:0] grs, input logic [7:0] e,
                                  input logic sign, output logic [31:0] res, output logic [2:0] fl,
                                  output int lat);
        longint x, xs, m, rem, half;
        int p, k, ee, drop;
        logic nx;
        x = longint'({m_in, grs});
        if (x == 0) begin
            res = 32'd0; fl = 3'b000; lat = 2;
            return;
        end
        p = 0;
        for (int i = 27; i >= 0; i--) if (x[i] && p == 0) p = i;
        if (p == 27) begin
            ee = int'(e) + 1; drop = 4; xs = x; lat = 3;
        end else begin
            k = 26 - p;
            if (k > int'(e) - 1) k = int'(e) - 1;
            if (k > 24) k = 24;
            xs = x << k; ee = int'(e) - k; drop = 3; lat = 3 + k;
        end
        m    = xs >> drop;
        rem  = xs & ((longint'(1) << drop) - 1);
        half = longint'(1) << (drop - 1);
        nx   = (rem != 0);
        if (rem > half || (rem == half && m[0])) m = m + 1;
        if (m == (longint'(1) << 24)) begin
            m = m >> 1; ee = ee + 1;
        end
        if (ee >= 255) begin
            res = 32'h7F80_0000 | {sign, 31'd0}; fl = 3'b101;
        end else if (m < (longint'(1) << 23)) begin
            res = {sign, 8'd0, m[22:0]}; fl = {1'b0, nx, nx};
        end else begin
            res = {sign, ee[7:0], m[22:0]}; fl = {1'b0, 1'b0, nx};
        end
    endfunction

    task automatic drive(input logic [24:0] m, input logic [2:0] g, input logic [7:0] e, input logic s);
        @(negedge clk);
        bus.mant_sum = m;
        bus.grs_in   = g;
        bus.exp_in   = e;
        bus.sign_in  = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic accept_result();
        @(negedge clk) bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [24:0] m, input logic [2:0] g,
                             input logic [7:0] e, input logic s, input logic [31:0] exp_res,
                             input logic [2:0] exp_fl, input int exp_lat);
        int lat;
        drive(m, g, e, s);
        wait_result(lat);
        check({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, ".result"}, bus.result, exp_res);
        check({nm, ".flags"}, 32'({bus.flag_ovf, bus.flag_unf, bus.flag_nx}), 32'(exp_fl));
        check({nm, ".latency"}, 32'(lat), 32'(exp_lat));
        accept_result();
    endtask

    initial begin
        vec_t vecs[10];
        logic [31:0] mres;
        logic [2:0]  mfl;
        int          mlat;
        int          lat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mant_sum  = '0;
        bus.grs_in    = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;

        vecs[0] = '{25'h100_0000, 3'b000, 8'd127, 1'b0, 32'h4000_0000, 3'b000, 3};
        vecs[1] = '{25'h040_0000, 3'b000, 8'd127, 1'b0, 32'h3F00_0000, 3'b000, 4};
        vecs[2] = '{25'h080_0001, 3'b100, 8'd127, 1'b0, 32'h3F80_0002, 3'b001, 3};
        vecs[3] = '{25'h080_0000, 3'b100, 8'd127, 1'b0, 32'h3F80_0000, 3'b001, 3};
        vecs[4] = '{25'h0FF_FFFF, 3'b110, 8'd127, 1'b0, 32'h4000_0000, 3'b001, 3};
        vecs[5] = '{25'h100_0000, 3'b000, 8'd254, 1'b0, 32'h7F80_0000, 3'b101, 3};
        vecs[6] = '{25'h000_0000, 3'b000, 8'd100, 1'b1, 32'h0000_0000, 3'b000, 2};
        vecs[7] = '{25'h010_0000, 3'b000, 8'd3,   1'b0, 32'h0040_0000, 3'b000, 5};
        vecs[8] = '{25'h020_0000, 3'b011, 8'd2,   1'b0, 32'h0040_0001, 3'b011, 4};
        vecs[9] = '{25'h100_0000, 3'b000, 8'd127, 1'b1, 32'hC000_0000, 3'b000, 3};

        #12;
        check("reset.in_ready",  32'(bus.in_ready),  32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result",    bus.result,         32'd0);
        check("reset.flags", 32'({bus.flag_ovf, bus.flag_unf, bus.flag_nx}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].mant, vecs[i].grs, vecs[i].exp, vecs[i].sign,
                      vecs[i].res, vecs[i].flags, vecs[i].lat);

        // Result must hold, and no new bundle be taken, while writeback stalls.
        drive(25'h080_0000, 3'b100, 8'd127, 1'b0);
        wait_result(lat);
        check("bp.valid", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp.result%0d", c),   bus.result,          32'h3F80_0000);
            check($sformatf("bp.in_ready%0d", c), 32'(bus.in_ready),   32'd0);
            check($sformatf("bp.valid%0d", c),    32'(bus.out_valid),  32'd1);
        end
        accept_result();
        check("bp.after_ready", 32'(bus.in_ready), 32'd1);

        // Abort a long normalization with reset, then confirm a clean follow-on operation.
        drive(25'h000_0100, 3'b000, 8'd127, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("rst.busy_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.result",    bus.result,         32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_check("rst.next", 25'h100_0000, 3'b000, 8'd127, 1'b0, 32'h4000_0000, 3'b000, 3);

        for (int t = 0; t < 300; t++) begin
            logic [24:0] m;
            logic [2:0]  g;
            logic [7:0]  e;
            logic        s;
            int unsigned cls;
            cls = $urandom_range(0, 9);
            if (cls < 3) begin
                m = 25'h100_0000 | 25'($urandom_range(0, 32'hFF_FFFF));
                g = 3'($urandom_range(0, 7));
            end else if (cls < 6) begin
                m = 25'h080_0000 | 25'($urandom_range(0, 32'h7F_FFFF));
                g = 3'($urandom_range(0, 7));
            end else if (cls < 9) begin
                m = 25'($urandom_range(0, 32'hFF_FFFF) >> (1 + $urandom_range(0, 23)));
                g = {1'($urandom_range(0, 1)), 2'b00};
            end else begin
                m = '0;
                g = '0;
            end
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 254)) : 8'($urandom_range(2, 254));
            s = 1'($urandom_range(0, 1));
            model(m, g, e, s, mres, mfl, mlat);
            run_check($sformatf("rand%0d", t), m, g, e, s, mres, mfl, mlat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
